// File: rtl/boreal_bus_master_bridge_if.sv
// Command, response and interconnect-side signal bundle for the bus master bridge.
// The bridge plugs in through the slave modport (it serves the command stream).
// The upstream agent and bus slave model use the master modport.
interface boreal_bus_master_bridge_if;
  // command stream (CPU LSU / DMA -> bridge)
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_wr;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_strb;
  // response stream (bridge -> consumer)
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  // interconnect master port
  logic        bus_req;
  logic        bus_wr;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_strb;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        bus_err;

  modport slave (
    input  cmd_valid, cmd_wr, cmd_addr, cmd_wdata, cmd_strb,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  rsp_ready,
    output bus_req, bus_wr, bus_addr, bus_wdata, bus_strb,
    input  bus_rdata, bus_ack, bus_err
  );

  modport master (
    output cmd_valid, cmd_wr, cmd_addr, cmd_wdata, cmd_strb,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output rsp_ready,
    input  bus_req, bus_wr, bus_addr, bus_wdata, bus_strb,
    output bus_rdata, bus_ack, bus_err
  );
endinterface

// File: rtl/boreal_bus_master_bridge.sv
// Upstream master adapter: a valid/ready command becomes a held req/ack bus
// transaction, and the outcome comes back as a valid/ready response.
// One transaction in flight. Misaligned addresses are rejected without touching the bus.
// A bounded ack wait aborts stuck transactions and counts them in a saturating counter.
module boreal_bus_master_bridge #(
  parameter int TIMEOUT_W = 8,
  parameter int TIMEOUT   = 200,
  parameter int STAT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  boreal_bus_master_bridge_if.slave bif,
  output logic [STAT_W-1:0]    stat_timeouts
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [TIMEOUT_W-1:0] CNT_LAST = TIMEOUT_W'(TIMEOUT - 1);
  localparam logic [TIMEOUT_W-1:0] CNT_ONE  = TIMEOUT_W'(1);
  localparam logic [STAT_W-1:0]    STAT_ONE = STAT_W'(1);
  localparam logic [STAT_W-1:0]    STAT_MAX = {STAT_W{1'b1}};

  state_e                state_q,       state_d;
  logic [TIMEOUT_W-1:0]  cnt_q,         cnt_d;
  logic [STAT_W-1:0]     stat_q,        stat_d;
  // bus_* are held in registers so they are zero outside REQ and glitch-free
  logic                  bus_req_q,     bus_req_d;
  logic                  bus_wr_q,      bus_wr_d;
  logic [31:0]           bus_addr_q,    bus_addr_d;
  logic [31:0]           bus_wdata_q,   bus_wdata_d;
  logic [3:0]            bus_strb_q,    bus_strb_d;
  logic                  rsp_valid_q,   rsp_valid_d;
  logic [31:0]           rsp_rdata_q,   rsp_rdata_d;
  logic                  rsp_err_q,     rsp_err_d;
  logic                  rsp_timeout_q, rsp_timeout_d;
  logic                  cmd_ready_s;
  logic                  accept_s;

  // cmd_ready is forced low by reset itself, not just by the reset state
  assign cmd_ready_s = (state_q == ST_IDLE) && rst_n;
  assign accept_s    = bif.cmd_valid && cmd_ready_s;

  assign bif.cmd_ready   = cmd_ready_s;
  assign bif.bus_req     = bus_req_q;
  assign bif.bus_wr      = bus_wr_q;
  assign bif.bus_addr    = bus_addr_q;
  assign bif.bus_wdata   = bus_wdata_q;
  assign bif.bus_strb    = bus_strb_q;
  assign bif.rsp_valid   = rsp_valid_q;
  assign bif.rsp_rdata   = rsp_rdata_q;
  assign bif.rsp_err     = rsp_err_q;
  assign bif.rsp_timeout = rsp_timeout_q;
  assign stat_timeouts   = stat_q;

  // State and datapath registers; reset discards any in-flight transaction
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      stat_q        <= '0;
      bus_req_q     <= 1'b0;
      bus_wr_q      <= 1'b0;
      bus_addr_q    <= 32'h0000_0000;
      bus_wdata_q   <= 32'h0000_0000;
      bus_strb_q    <= 4'h0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= 32'h0000_0000;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      stat_q        <= stat_d;
      bus_req_q     <= bus_req_d;
      bus_wr_q      <= bus_wr_d;
      bus_addr_q    <= bus_addr_d;
      bus_wdata_q   <= bus_wdata_d;
      bus_strb_q    <= bus_strb_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  // Next-state and next-output logic for IDLE -> REQ -> RESP -> IDLE
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    stat_d        = stat_q;
    bus_req_d     = bus_req_q;
    bus_wr_d      = bus_wr_q;
    bus_addr_d    = bus_addr_q;
    bus_wdata_d   = bus_wdata_q;
    bus_strb_d    = bus_strb_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;

    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          if (bif.cmd_addr[1:0] != 2'b00) begin
            // misaligned: answer immediately, never drive the bus
            state_d       = ST_RESP;
            rsp_valid_d   = 1'b1;
            rsp_err_d     = 1'b1;
            rsp_timeout_d = 1'b0;
            rsp_rdata_d   = 32'h0000_0000;
          end else begin
            state_d     = ST_REQ;
            cnt_d       = '0;
            bus_req_d   = 1'b1;
            bus_wr_d    = bif.cmd_wr;
            bus_addr_d  = bif.cmd_addr;
            bus_wdata_d = bif.cmd_wdata;
            bus_strb_d  = bif.cmd_strb;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_REQ: begin
        if (bif.bus_ack || (cnt_q == CNT_LAST)) begin
          // either way the bus is released next cycle
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          bus_req_d   = 1'b0;
          bus_wr_d    = 1'b0;
          bus_addr_d  = 32'h0000_0000;
          bus_wdata_d = 32'h0000_0000;
          bus_strb_d  = 4'h0;
          if (bif.bus_ack) begin
            // ack beats a coincident timeout
            rsp_err_d     = bif.bus_err;
            rsp_timeout_d = 1'b0;
            rsp_rdata_d   = (!bus_wr_q && !bif.bus_err) ? bif.bus_rdata : 32'h0000_0000;
          end else begin
            rsp_err_d     = 1'b1;
            rsp_timeout_d = 1'b1;
            rsp_rdata_d   = 32'h0000_0000;
            stat_d        = (stat_q == STAT_MAX) ? stat_q : (stat_q + STAT_ONE);
          end
        end else begin
          // every unacknowledged cycle counts, including lost arbitration
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_RESP: begin
        if (bif.rsp_ready) begin
          state_d       = ST_IDLE;
          rsp_valid_d   = 1'b0;
          rsp_rdata_d   = 32'h0000_0000;
          rsp_err_d     = 1'b0;
          rsp_timeout_d = 1'b0;
        end else begin
          state_d = ST_RESP;
        end
      end

      default: begin
        state_d       = ST_IDLE;
        cnt_d         = '0;
        bus_req_d     = 1'b0;
        bus_wr_d      = 1'b0;
        bus_addr_d    = 32'h0000_0000;
        bus_wdata_d   = 32'h0000_0000;
        bus_strb_d    = 4'h0;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = 32'h0000_0000;
        rsp_err_d     = 1'b0;
        rsp_timeout_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_boreal_bus_master_bridge.sv
// Directed self-checking bench for boreal_bus_master_bridge.
// Inputs change 1 ns after a rising edge and outputs are sampled at that same point.
module tb_boreal_bus_master_bridge;

  logic        clk;
  logic        rst_n;
  logic [15:0] stat;
  int          errors;
  int          checks;

  boreal_bus_master_bridge_if bif ();

  boreal_bus_master_bridge #(
    .TIMEOUT_W (8),
    .TIMEOUT   (200),
    .STAT_W    (16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bif           (bif.slave),
    .stat_timeouts (stat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] strb);
    bif.cmd_valid = 1'b1;
    bif.cmd_wr    = wr;
    bif.cmd_addr  = addr;
    bif.cmd_wdata = wdata;
    bif.cmd_strb  = strb;
  endtask

  task automatic rsp_handshake();
    bif.rsp_ready = 1'b1;
    tick();
    bif.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if (bif.cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_cmd_ready: got %b expected 0", bif.cmd_ready); end
    checks++;
    if (bif.bus_req !== 1'b0 || bif.bus_addr !== 32'h0) begin errors++; $display("FAIL rst_bus: req %b addr %h expected 0/0", bif.bus_req, bif.bus_addr); end
    checks++;
    if (bif.rsp_valid !== 1'b0 || bif.rsp_err !== 1'b0) begin errors++; $display("FAIL rst_rsp: valid %b err %b expected 0/0", bif.rsp_valid, bif.rsp_err); end
    checks++;
    if (stat !== 16'd0) begin errors++; $display("FAIL rst_stat: got %0d expected 0", stat); end
    rst_n = 1'b1;
    #1;
    checks++;
    if (bif.cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b expected 1", bif.cmd_ready); end
  endtask

  // T1: aligned read, ack in the first REQ cycle
  task automatic test_read_fast();
    drive_cmd(1'b0, 32'h0000_1004, 32'h0, 4'hF);
    checks++;
    if (bif.cmd_ready !== 1'b1) begin errors++; $display("FAIL t1_accept: cmd_ready %b expected 1", bif.cmd_ready); end
    tick();
    bif.cmd_valid = 1'b0;
    checks++;
    if (bif.bus_req !== 1'b1 || bif.bus_addr !== 32'h0000_1004 || bif.bus_wr !== 1'b0) begin
      errors++; $display("FAIL t1_bus: req %b addr %h wr %b expected 1 00001004 0", bif.bus_req, bif.bus_addr, bif.bus_wr);
    end
    bif.bus_ack = 1'b1; bif.bus_rdata = 32'hDEAD_BEEF;
    tick();
    bif.bus_ack = 1'b0; bif.bus_rdata = 32'h0;
    checks++;
    if (bif.bus_req !== 1'b0) begin errors++; $display("FAIL t1_req_once: bus_req %b expected 0", bif.bus_req); end
    checks++;
    if (bif.rsp_valid !== 1'b1 || bif.rsp_rdata !== 32'hDEAD_BEEF || bif.rsp_err !== 1'b0 || bif.rsp_timeout !== 1'b0) begin
      errors++; $display("FAIL t1_rsp: valid %b rdata %h err %b to %b expected 1 deadbeef 0 0",
                         bif.rsp_valid, bif.rsp_rdata, bif.rsp_err, bif.rsp_timeout);
    end
    rsp_handshake();
    checks++;
    if (bif.rsp_valid !== 1'b0 || bif.cmd_ready !== 1'b1) begin errors++; $display("FAIL t1_done: rsp_valid %b cmd_ready %b expected 0 1", bif.rsp_valid, bif.cmd_ready); end
  endtask

  // T2: write, ack arrives on the fourth REQ cycle
  task automatic test_write_wait();
    drive_cmd(1'b1, 32'h1003_0000, 32'h1234_5678, 4'hF);
    tick();
    bif.cmd_valid = 1'b0;
    bif.bus_rdata = 32'hAAAA_5555;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (bif.bus_req !== 1'b1 || bif.bus_wr !== 1'b1 || bif.bus_addr !== 32'h1003_0000 ||
          bif.bus_wdata !== 32'h1234_5678 || bif.bus_strb !== 4'hF) begin
        errors++; $display("FAIL t2_bus_stable[%0d]: req %b wr %b addr %h wdata %h strb %h", k,
                           bif.bus_req, bif.bus_wr, bif.bus_addr, bif.bus_wdata, bif.bus_strb);
      end
      if (k == 3) bif.bus_ack = 1'b1;
      tick();
    end
    bif.bus_ack = 1'b0; bif.bus_rdata = 32'h0;
    checks++;
    if (bif.bus_req !== 1'b0 || bif.bus_addr !== 32'h0 || bif.bus_wdata !== 32'h0) begin
      errors++; $display("FAIL t2_bus_clear: req %b addr %h wdata %h expected 0", bif.bus_req, bif.bus_addr, bif.bus_wdata);
    end
    checks++;
    if (bif.rsp_valid !== 1'b1 || bif.rsp_rdata !== 32'h0 || bif.rsp_err !== 1'b0) begin
      errors++; $display("FAIL t2_rsp: valid %b rdata %h err %b expected 1 0 0", bif.rsp_valid, bif.rsp_rdata, bif.rsp_err);
    end
    rsp_handshake();
  endtask

  // T3: timeout after 200 REQ cycles, then ack on the 200th cycle
  task automatic test_timeout();
    int n;
    drive_cmd(1'b0, 32'h3000_0000, 32'h0, 4'hF);
    tick();
    bif.cmd_valid = 1'b0;
    n = 0;
    while (bif.bus_req === 1'b1 && n < 300) begin
      n++;
      tick();
    end
    checks++;
    if (n != 200) begin errors++; $display("FAIL t3_req_cycles: got %0d expected 200", n); end
    checks++;
    if (bif.rsp_valid !== 1'b1 || bif.rsp_err !== 1'b1 || bif.rsp_timeout !== 1'b1 || bif.rsp_rdata !== 32'h0) begin
      errors++; $display("FAIL t3_rsp: valid %b err %b to %b rdata %h expected 1 1 1 0",
                         bif.rsp_valid, bif.rsp_err, bif.rsp_timeout, bif.rsp_rdata);
    end
    checks++;
    if (stat !== 16'd1) begin errors++; $display("FAIL t3_stat: got %0d expected 1", stat); end
    rsp_handshake();

    drive_cmd(1'b0, 32'h3000_0000, 32'h0, 4'hF);
    tick();
    bif.cmd_valid = 1'b0;
    for (int i = 0; i < 199; i++) tick();
    checks++;
    if (bif.bus_req !== 1'b1) begin errors++; $display("FAIL t3_req_200th: bus_req %b expected 1", bif.bus_req); end
    bif.bus_ack = 1'b1; bif.bus_rdata = 32'h0BAD_F00D;
    tick();
    bif.bus_ack = 1'b0; bif.bus_rdata = 32'h0;
    checks++;
    if (bif.rsp_valid !== 1'b1 || bif.rsp_err !== 1'b0 || bif.rsp_timeout !== 1'b0 || bif.rsp_rdata !== 32'h0BAD_F00D) begin
      errors++; $display("FAIL t3_ack_wins: valid %b err %b to %b rdata %h expected 1 0 0 0badf00d",
                         bif.rsp_valid, bif.rsp_err, bif.rsp_timeout, bif.rsp_rdata);
    end
    checks++;
    if (stat !== 16'd1) begin errors++; $display("FAIL t3_stat_hold: got %0d expected 1", stat); end
    rsp_handshake();
  endtask

  // T4: misaligned address is answered without a bus cycle
  task automatic test_misaligned();
    drive_cmd(1'b0, 32'h0000_1002, 32'h0, 4'hF);
    tick();
    bif.cmd_valid = 1'b0;
    checks++;
    if (bif.bus_req !== 1'b0) begin errors++; $display("FAIL t4_no_req: bus_req %b expected 0", bif.bus_req); end
    checks++;
    if (bif.rsp_valid !== 1'b1 || bif.rsp_err !== 1'b1 || bif.rsp_timeout !== 1'b0 || bif.rsp_rdata !== 32'h0) begin
      errors++; $display("FAIL t4_rsp: valid %b err %b to %b rdata %h expected 1 1 0 0",
                         bif.rsp_valid, bif.rsp_err, bif.rsp_timeout, bif.rsp_rdata);
    end
    rsp_handshake();
  endtask

  // T5: bus error on ack, response held while consumer stalls
  task automatic test_bus_err_stall();
    drive_cmd(1'b0, 32'h2000_0008, 32'h0, 4'hF);
    tick();
    bif.cmd_valid = 1'b0;
    bif.bus_ack = 1'b1; bif.bus_err = 1'b1; bif.bus_rdata = 32'hFFFF_FFFF;
    tick();
    bif.bus_ack = 1'b0; bif.bus_err = 1'b0; bif.bus_rdata = 32'h0;
    drive_cmd(1'b1, 32'h0000_2000, 32'h5555_AAAA, 4'h3);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (bif.rsp_valid !== 1'b1 || bif.rsp_err !== 1'b1 || bif.rsp_rdata !== 32'h0 ||
          bif.rsp_timeout !== 1'b0 || bif.cmd_ready !== 1'b0 || bif.bus_req !== 1'b0) begin
        errors++; $display("FAIL t5_stall[%0d]: valid %b err %b rdata %h to %b cmd_ready %b req %b", k,
                           bif.rsp_valid, bif.rsp_err, bif.rsp_rdata, bif.rsp_timeout, bif.cmd_ready, bif.bus_req);
      end
      tick();
    end
    bif.cmd_valid = 1'b0;
    rsp_handshake();
  endtask

  // Next command is taken the cycle after the response handshake
  task automatic test_back_to_back();
    drive_cmd(1'b1, 32'h0000_0040, 32'hCAFE_0001, 4'h1);
    tick();
    bif.bus_ack = 1'b1;
    tick();
    bif.bus_ack = 1'b0;
    drive_cmd(1'b0, 32'h0000_0080, 32'h0, 4'hF);
    bif.rsp_ready = 1'b1;
    tick();
    bif.rsp_ready = 1'b0;
    checks++;
    if (bif.cmd_ready !== 1'b1 || bif.bus_req !== 1'b0 || bif.rsp_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_idle: cmd_ready %b req %b rsp_valid %b expected 1 0 0", bif.cmd_ready, bif.bus_req, bif.rsp_valid);
    end
    tick();
    bif.cmd_valid = 1'b0;
    checks++;
    if (bif.bus_req !== 1'b1 || bif.bus_addr !== 32'h0000_0080 || bif.bus_wr !== 1'b0) begin
      errors++; $display("FAIL b2b_second: req %b addr %h wr %b expected 1 00000080 0", bif.bus_req, bif.bus_addr, bif.bus_wr);
    end
    bif.bus_ack = 1'b1; bif.bus_rdata = 32'h0000_0077;
    tick();
    bif.bus_ack = 1'b0; bif.bus_rdata = 32'h0;
    checks++;
    if (bif.rsp_rdata !== 32'h0000_0077 || bif.rsp_valid !== 1'b1) begin
      errors++; $display("FAIL b2b_rsp: rdata %h valid %b expected 00000077 1", bif.rsp_rdata, bif.rsp_valid);
    end
    rsp_handshake();
  endtask

  // T6: reset while the bus request is outstanding
  task automatic test_reset_mid();
    drive_cmd(1'b0, 32'h0000_0100, 32'h0, 4'hF);
    tick();
    bif.cmd_valid = 1'b0;
    checks++;
    if (bif.bus_req !== 1'b1 || stat !== 16'd1) begin errors++; $display("FAIL t6_pre: req %b stat %0d expected 1 1", bif.bus_req, stat); end
    rst_n = 1'b0;
    tick();
    checks++;
    if (bif.bus_req !== 1'b0 || bif.rsp_valid !== 1'b0 || bif.cmd_ready !== 1'b0 || stat !== 16'd0) begin
      errors++; $display("FAIL t6_in_reset: req %b rsp_valid %b cmd_ready %b stat %0d expected 0 0 0 0",
                         bif.bus_req, bif.rsp_valid, bif.cmd_ready, stat);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (bif.cmd_ready !== 1'b1) begin errors++; $display("FAIL t6_release: cmd_ready %b expected 1", bif.cmd_ready); end
    tick();
    checks++;
    if (bif.bus_req !== 1'b0 || bif.rsp_valid !== 1'b0) begin
      errors++; $display("FAIL t6_after: req %b rsp_valid %b expected 0 0", bif.bus_req, bif.rsp_valid);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    bif.cmd_valid = 1'b0; bif.cmd_wr = 1'b0; bif.cmd_addr = 32'h0;
    bif.cmd_wdata = 32'h0; bif.cmd_strb = 4'h0; bif.rsp_ready = 1'b0;
    bif.bus_rdata = 32'h0; bif.bus_ack = 1'b0; bif.bus_err = 1'b0;
    test_reset();
    test_read_fast();
    test_write_wait();
    test_timeout();
    test_misaligned();
    test_bus_err_stall();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
